dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_arbiter.sv | 88 ++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults, data-memory opcodes and tile-id sizing for the CGRA data-memory controller.
package dmem_pkg;

    localparam int DMEM_ADDR_W    = 10;
    localparam int DMEM_DATA_W    = 48;
    localparam int DMEM_NUM_TILES = 4;

    localparam logic [2:0] OP_DMEM_STORE = 3'b001;
    localparam logic [2:0] OP_DMEM_LOAD  = 3'b010;

    function automatic int tile_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, 1-cycle read latency, read data held while idle.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst) rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter serializing tile load/store requests onto one shared RAM port.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_TILES = DMEM_NUM_TILES,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          program_mode,
    input  logic [NUM_TILES-1:0]          req,
    input  logic [NUM_TILES-1:0]          we,
    input  logic [NUM_TILES*ADDR_W-1:0]   addr,
    input  logic [NUM_TILES*DATA_W-1:0]   wdata,
    output logic [NUM_TILES-1:0]          gnt,
    output logic [NUM_TILES-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata
);

    localparam int ID_W = tile_id_w(NUM_TILES);

    logic [NUM_TILES-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d, elig;
    logic [ID_W-1:0]      last_q, last_d, tag_q, tag_d, win;
    logic                 found, go;
    logic                 ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;

    always_comb begin
        elig  = req & ~gnt_q;
        win   = last_q;
        found = 1'b0;
        // Scan farthest-first so the nearest eligible tile after last_q overrides.
        for (int i = NUM_TILES; i >= 1; i--) begin
            if (elig[(int'(last_q) + i) % NUM_TILES]) begin
                win   = ID_W'((int'(last_q) + i) % NUM_TILES);
                found = 1'b1;
            end
        end
        go          = found && !program_mode;
        gnt_d       = go ? NUM_TILES'(1) << win : '0;
        last_d      = go ? win : last_q;
        tag_d       = go ? win : tag_q;
        ram_en_d    = go;
        ram_we_d    = go && we[win];
        ram_addr_d  = addr[win*ADDR_W +: ADDR_W];
        ram_wdata_d = wdata[win*DATA_W +: DATA_W];
        rvalid_d    = (ram_en_q && !ram_we_q) ? NUM_TILES'(1) << tag_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            last_q   <= ID_W'(NUM_TILES - 1);
            tag_q    <= '0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
        end else begin
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
        end
    end

    always_ff @(posedge clk) begin
        ram_addr_q  <= ram_addr_d;
        ram_wdata_q <= ram_wdata_d;
    end

    dmem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en_q),
        .we    (ram_we_q),
        .addr  (ram_addr_q),
        .wdata (ram_wdata_q),
        .rdata (rdata)
    );

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed grant checks plus a load-data scoreboard backed by a memory model.
module tb_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 48;

    logic          clk = 0, rst = 0, program_mode = 0;
    logic [N-1:0]  req = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  gnt, rvalid;
    logic [DW-1:0] rdata;

    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {
        int           tile;
        logic [DW-1:0] data;
        int           due;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    logic [DW-1:0]   mm [int];
    logic [N-1:0]    p_we;
    logic [N*AW-1:0] p_addr;
    logic [N*DW-1:0] p_wdata;
    int              a;

    dmem_arbiter #(.NUM_TILES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .program_mode (program_mode),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tile(input int k, input logic r, input logic w,
                            input logic [AW-1:0] ad, input logic [DW-1:0] d);
        req[k]             = r;
        we[k]              = w;
        addr[k*AW +: AW]   = ad;
        wdata[k*DW +: DW]  = d;
    endtask

    // Scoreboard: a grant observed now was decided on last cycle's inputs.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            check("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
            check("rvalid_onehot", 64'($onehot0(rvalid)), 64'd1);
            if (rvalid != '0) begin
                if (sb.size() == 0) begin
                    check("rvalid_spurious", 64'(rvalid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_tile", 64'(rvalid), 64'(1) << e.tile);
                    check("rdata", 64'(rdata), 64'(e.data));
                    check("rvalid_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rvalid_missing", 64'(rvalid), 64'(1) << e.tile);
            end
            for (int k = 0; k < N; k++) begin
                if (gnt[k]) begin
                    a = int'(p_addr[k*AW +: AW]);
                    if (p_we[k]) mm[a] = p_wdata[k*DW +: DW];
                    else sb.push_back('{tile: k, data: mm[a], due: cyc + 1});
                end
            end
        end
        p_we    = we;
        p_addr  = addr;
        p_wdata = wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then store/load on tile 0
        step();
        step();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst = 1;
        set_tile(0, 1, 1, 10'd5, 48'h0000_DEAD_BEEF);
        step();
        check("t1_store_gnt", 64'(gnt), 64'b0001);
        req[0] = 0;
        step();
        check("t1_idle_gnt", 64'(gnt), 64'd0);
        set_tile(0, 1, 0, 10'd5, '0);
        step();
        check("t1_load_gnt", 64'(gnt), 64'b0001);
        req[0] = 0;
        step();
        check("t1_rvalid", 64'(rvalid), 64'b0001);
        check("t1_rdata", 64'(rdata), 64'h0000_DEAD_BEEF);

        // All-tile contention from reset: stores, then loads
        rst = 0;
        step();
        rst = 1;
        for (int k = 0; k < N; k++) set_tile(k, 1, 1, AW'(10 + k), DW'(100 + k));
        for (int i = 0; i < 12; i++) begin
            step();
            check("rr_gnt", 64'(gnt), 64'(1) << (i % N));
            if (i >= 8) req[i % N] = 0;
            else if (i >= 4) we[i % N] = 0;
        end
        step();
        step();

        // Store-then-load hazard at the top address
        set_tile(2, 1, 1, 10'd1023, 48'h1234);
        set_tile(3, 1, 0, 10'd1023, '0);
        step();
        check("hz_gnt_store", 64'(gnt), 64'b0100);
        req[2] = 0;
        step();
        check("hz_gnt_load", 64'(gnt), 64'b1000);
        req[3] = 0;
        step();
        check("hz_rvalid", 64'(rvalid), 64'b1000);
        check("hz_rdata", 64'(rdata), 64'h1234);

        // Single continuous requester
        set_tile(1, 1, 0, 10'd5, '0);
        for (int i = 0; i < 9; i++) begin
            step();
            check("single_gnt", 64'(gnt), (i % 2 == 0) ? 64'b0010 : 64'd0);
        end
        req[1] = 0;
        step();
        step();

        // program_mode rising in a load's grant cycle
        set_tile(0, 1, 0, 10'd5, '0);
        step();
        check("pm_gnt0", 64'(gnt), 64'b0001);
        program_mode = 1;
        req[0] = 0;
        set_tile(1, 1, 0, 10'd1023, '0);
        step();
        check("pm_gnt_blocked", 64'(gnt), 64'd0);
        check("pm_rvalid0", 64'(rvalid), 64'b0001);
        check("pm_rdata0", 64'(rdata), 64'h0000_DEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            check("pm_hold", 64'(gnt), 64'd0);
        end
        program_mode = 0;
        step();
        check("pm_gnt1", 64'(gnt), 64'b0010);
        req[1] = 0;
        step();
        check("pm_rvalid1", 64'(rvalid), 64'b0010);
        check("pm_rdata1", 64'(rdata), 64'h1234);

        // Reset in a load's grant cycle
        set_tile(0, 1, 0, 10'd5, '0);
        step();
        check("mr_gnt", 64'(gnt), 64'b0001);
        req[0] = 0;
        rst = 0;
        step();
        check("mr_gnt_rst", 64'(gnt), 64'd0);
        check("mr_rvalid_rst", 64'(rvalid), 64'd0);
        check("mr_rdata_rst", 64'(rdata), 64'd0);
        rst = 1;
        set_tile(0, 1, 0, 10'd5, '0);
        set_tile(1, 1, 0, 10'd1023, '0);
        step();
        check("mr_first_gnt", 64'(gnt), 64'b0001);
        req[0] = 0;
        step();
        check("mr_second_gnt", 64'(gnt), 64'b0010);
        check("mr_rvalid0", 64'(rvalid), 64'b0001);
        req[1] = 0;
        step();
        check("mr_rvalid1", 64'(rvalid), 64'b0010);
        check("mr_rdata1", 64'(rdata), 64'h1234);
        step();
        step();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
